sram_line_ctrl: RTL and testbench

Sequencing controller between the data cache's miss/write-through path and the off-chip 16-bit SRAM. It accepts one 64-bit line-fill read or one 32-bit word write at a time, and splits it into halfword SRAM beats with a programmable wait-state count. It produces the `ready` signal that freezes the pipeline (`Freeze = ~ready`) while an access is in flight. It sits between the cache controller in the MEM stage and the SRAM pins/model.

---
 rtl/sram_ctrl_pkg.sv | 55 +++++
 rtl/sram_beat_timer.sv | 66 ++++++
 rtl/sram_line_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sram_line_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//
// Shared definitions for the cache-to-SRAM line controller:
//   - controller state encoding
//   - beat counts for a line fill and a word write
//   - SRAM halfword width and the counter widths used by the beat timer
//   - small helpers that form SRAM halfword addresses and pick write halves
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  // Controller states: waiting for a request, fetching a line, writing a
  // word, and the single completion cycle that releases the pipeline.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // A cache line is 64 bits = 4 halfwords; a word write is 2 halfwords.
  localparam int LINE_BEATS = 4;
  localparam int WORD_BEATS = 2;

  // Width of one SRAM data beat.
  localparam int HW_WIDTH = 16;

  // Native width of a halfword address formed from byte address bits [18:1].
  localparam int HW_ADDR_W = 18;

  // Counter widths inside the beat timer.
  localparam int WAIT_W = 3;
  localparam int BEAT_W = 2;

  // Halfword address of beat 'beat' inside the line selected by line_idx
  // (line_idx is byte address bits [18:3]).
  function automatic logic [HW_ADDR_W-1:0] line_hw_addr(input logic [15:0] line_idx,
                                                        input logic [1:0]  beat);
    return {line_idx, beat};
  endfunction

  // Halfword address of the low (half=0) or high (half=1) half of the word
  // selected by word_idx (word_idx is byte address bits [18:2]).
  function automatic logic [HW_ADDR_W-1:0] word_hw_addr(input logic [16:0] word_idx,
                                                        input logic        half);
    return {word_idx, half};
  endfunction

  // Halfword of a 32-bit write word that goes out on a given write beat.
  function automatic logic [HW_WIDTH-1:0] word_half(input logic [31:0] word,
                                                    input logic        half);
    return half ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
//
// Wait-state / beat counter pair for the SRAM sequencer. Each beat lasts
// WAIT_CYCLES+1 cycles; the wait counter counts cycles inside the beat and
// the beat counter counts beats inside the access.
//
// Ports:
//   clk             in  rising-edge clock
//   rst             in  synchronous active-high reset
//   clear           in  hold both counters at zero (idle / between accesses)
//   run             in  advance the counters by one cycle
//   beat_last_cycle out high on the final cycle of the current beat
//   beat_idx        out index of the current beat within the access
// ---------------------------------------------------------------------------
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  output logic              beat_last_cycle,
  output logic [BEAT_W-1:0] beat_idx
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign beat_last_cycle = (wait_q == WAIT_LAST);
  assign beat_idx        = beat_q;

  // The wait counter restarts at every beat boundary; the beat counter is
  // allowed to wrap because the controller leaves the state on the last beat
  // and clears the pair before the next access.
  always_comb begin
    wait_d = wait_q;
    beat_d = beat_q;
    if (clear) begin
      wait_d = '0;
      beat_d = '0;
    end else if (run) begin
      if (beat_last_cycle) begin
        wait_d = '0;
        beat_d = beat_q + BEAT_W'(1);
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_line_ctrl.sv
// ---------------------------------------------------------------------------
// sram_line_ctrl
//
// Sequencer between the data cache miss / write-through path and a 16-bit
// off-chip SRAM. Accepts one 64-bit line fill or one 32-bit word write at a
// time and breaks it into halfword beats of WAIT_CYCLES+1 cycles each.
// 'ready' is low while an access is outstanding so the pipeline can freeze.
//
// Ports:
//   clk        in     rising-edge clock
//   rst        in     synchronous active-high reset
//   rd_req     in     line-fill request, held until ready is seen high
//   wr_req     in     word-write request, held until ready is seen high
//   addr       in     byte address into SRAM space, bits [18:0] used
//   wdata      in     write word
//   rdata      out    last filled line, halfword k at [16k+15:16k]
//   rvalid     out    one-cycle pulse when rdata holds a completed line
//   ready      out    high when no access is outstanding
//   SRAM_DQ    inout  SRAM data bus, driven only during write beats
//   SRAM_ADDR  out    registered SRAM halfword address
//   SRAM_WE_N  out    registered SRAM write enable, active low
// ---------------------------------------------------------------------------
module sram_line_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req,
  input  logic               wr_req,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [63:0]        rdata,
  output logic               rvalid,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  localparam logic [BEAT_W-1:0] LAST_LINE_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_WORD_BEAT = BEAT_W'(WORD_BEATS - 1);

  ctrl_state_e state_q, state_d;

  // Only byte address bits [18:2] matter: reads use [18:3], writes [18:2].
  logic [16:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [HW_WIDTH-1:0] dq_out_q, dq_out_d;

  logic                timer_clear;
  logic                timer_run;
  logic                beat_last_cycle;
  logic [BEAT_W-1:0]   beat_idx;

  // Byte-lane bits and the bits above the SRAM window are intentionally
  // ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:19], addr[1:0]};

  sram_beat_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .clear          (timer_clear),
    .run            (timer_run),
    .beat_last_cycle(beat_last_cycle),
    .beat_idx       (beat_idx)
  );

  // Next-state and next-output logic. All SRAM pin values are computed one
  // cycle ahead so the pins only change on clock edges: the first beat is
  // set up on the accepting edge, and each following beat is set up on the
  // last cycle of the one before it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    sram_addr_d = sram_addr_q;
    we_n_d      = we_n_q;
    dq_oe_d     = dq_oe_q;
    dq_out_d    = dq_out_q;
    timer_clear = 1'b1;
    timer_run   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A write takes priority; a simultaneous read stays pending at the
        // input and is picked up on the idle cycle after this write's DONE.
        if (wr_req) begin
          state_d     = ST_WRITE;
          addr_d      = addr[18:2];
          wdata_d     = wdata;
          sram_addr_d = SRAM_AW'(word_hw_addr(addr[18:2], 1'b0));
          we_n_d      = 1'b0;
          dq_oe_d     = 1'b1;
          dq_out_d    = word_half(wdata, 1'b0);
        end else if (rd_req) begin
          state_d     = ST_READ;
          addr_d      = addr[18:2];
          sram_addr_d = SRAM_AW'(line_hw_addr(addr[18:3], 2'd0));
        end
      end

      ST_READ: begin
        timer_clear = 1'b0;
        timer_run   = 1'b1;
        if (beat_last_cycle) begin
          // Sample the bus at the end of the beat, after the SRAM has had
          // all of its wait states to settle.
          for (int k = 0; k < LINE_BEATS; k++) begin
            if (beat_idx == BEAT_W'(k)) begin
              rdata_d[k*HW_WIDTH +: HW_WIDTH] = SRAM_DQ;
            end
          end
          if (beat_idx == LAST_LINE_BEAT) begin
            state_d  = ST_DONE;
            rvalid_d = 1'b1;
          end else begin
            sram_addr_d = SRAM_AW'(line_hw_addr(addr_q[16:1], beat_idx + BEAT_W'(1)));
          end
        end
      end

      ST_WRITE: begin
        timer_clear = 1'b0;
        timer_run   = 1'b1;
        if (beat_last_cycle) begin
          if (beat_idx == LAST_WORD_BEAT) begin
            // WE_N rises and the bus is released on the edge leaving the
            // final write beat.
            state_d = ST_DONE;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
          end else begin
            sram_addr_d = SRAM_AW'(word_hw_addr(addr_q, 1'b1));
            dq_out_d    = word_half(wdata_q, 1'b1);
          end
        end
      end

      ST_DONE: begin
        // Requests seen here belong to the instruction leaving MEM.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state/output register; reset aborts any access in flight, so a
  // partial line never raises rvalid and the bus is released at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // Ready is combinational so an idle controller freezes the pipeline in the
  // same cycle a request appears.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      ST_IDLE: ready = ~(rd_req | wr_req);
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {HW_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_line_ctrl
//
// Two controller instances: one with one wait state (main tests, backed by a
// behavioural SRAM array) and one with zero wait states (write timing).
// Expected addresses, bus data, latencies and lines come from the access
// rules: beat length W+1, line = 4 halfwords at {addr[18:3],k}, word = 2
// halfwords at {addr[18:2],k}.
// ---------------------------------------------------------------------------
module tb_sram_line_ctrl;

  localparam int W1       = 1;
  localparam int W0       = 0;
  localparam int BEAT_LEN = W1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        rd_req, wr_req;
  logic [31:0] addr, wdata;
  logic [63:0] rdata;
  logic        rvalid, ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  logic        b_rd_req, b_wr_req;
  logic [31:0] b_addr, b_wdata;
  logic [63:0] b_rdata;
  logic        b_rvalid, b_ready;
  wire  [15:0] b_sram_dq;
  logic [17:0] b_sram_addr;
  logic        b_sram_we_n;

  // Behavioural SRAM contents (aliased on the low 12 address bits).
  logic [15:0] mem [0:4095];
  assign sram_dq = sram_we_n ? mem[sram_addr[11:0]] : 16'hzzzz;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_line;

  sram_line_ctrl #(.WAIT_CYCLES(W1), .SRAM_AW(18)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .ready    (ready),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n)
  );

  sram_line_ctrl #(.WAIT_CYCLES(W0), .SRAM_AW(18)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (b_rd_req),
    .wr_req   (b_wr_req),
    .addr     (b_addr),
    .wdata    (b_wdata),
    .rdata    (b_rdata),
    .rvalid   (b_rvalid),
    .ready    (b_ready),
    .SRAM_DQ  (b_sram_dq),
    .SRAM_ADDR(b_sram_addr),
    .SRAM_WE_N(b_sram_we_n)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    rd_req = rd;
    wr_req = wr;
    addr   = a;
    wdata  = d;
    #1;
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  // Full line fill starting in an idle cycle; returns in the idle cycle
  // after DONE.
  task automatic runRead(input logic [31:0] a);
    logic [17:0] base;
    logic [11:0] idx;
    logic [63:0] exp_line;
    base = {a[18:3], 2'b00};
    for (int k = 0; k < 4; k++) begin
      idx = base[11:0] + 12'(k);
      exp_line[16*k +: 16] = mem[idx];
    end
    applyStimulus(1'b1, 1'b0, a, $urandom);
    checkOutput("rd_accept_ready", ready, 0);
    for (int c = 1; c <= 4 * BEAT_LEN; c++) begin
      waitCycle();
      if (c == 2) begin
        addr  = $urandom;
        wdata = $urandom;
      end
      checkOutput("rd_busy_ready", ready, 0);
      checkOutput("rd_we_n", sram_we_n, 1);
      checkOutput("rd_sram_addr", sram_addr, base + 18'((c - 1) / BEAT_LEN));
      checkOutput("rd_rvalid_early", rvalid, 0);
    end
    waitCycle();
    checkOutput("rd_done_ready", ready, 1);
    checkOutput("rd_done_rvalid", rvalid, 1);
    checkOutput("rd_done_rdata", rdata, exp_line);
    last_line = exp_line;
    rd_req = 1'b0;
    waitCycle();
    checkOutput("rd_idle_ready", ready, 1);
    checkOutput("rd_idle_rvalid", rvalid, 0);
    checkOutput("rd_idle_rdata_held", rdata, last_line);
  endtask

  // Word write starting in an idle cycle; optionally holds rd_req with it.
  task automatic runWrite(input logic [31:0] a, input logic [31:0] d, input logic rd_too);
    logic [17:0] base;
    base = {a[18:2], 1'b0};
    applyStimulus(rd_too, 1'b1, a, d);
    checkOutput("wr_accept_ready", ready, 0);
    for (int c = 1; c <= 2 * BEAT_LEN; c++) begin
      waitCycle();
      if (c == 2) begin
        addr  = $urandom;
        wdata = $urandom;
      end
      checkOutput("wr_busy_ready", ready, 0);
      checkOutput("wr_we_n", sram_we_n, 0);
      checkOutput("wr_sram_addr", sram_addr, base + 18'((c - 1) / BEAT_LEN));
      checkOutput("wr_dq", sram_dq, ((c - 1) / BEAT_LEN == 0) ? d[15:0] : d[31:16]);
      checkOutput("wr_rvalid", rvalid, 0);
    end
    waitCycle();
    checkOutput("wr_done_ready", ready, 1);
    checkOutput("wr_done_rvalid", rvalid, 0);
    checkOutput("wr_done_we_n", sram_we_n, 1);
    checkOutput("wr_done_rdata_held", rdata, last_line);
    wr_req = 1'b0;
    waitCycle();
    checkOutput("wr_idle_ready", ready, rd_too ? 0 : 1);
    checkOutput("wr_idle_we_n", sram_we_n, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [17:0] base;
    int          op;

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[8]  = 16'h1111;
    mem[9]  = 16'h2222;
    mem[10] = 16'h3333;
    mem[11] = 16'h4444;

    rst      = 1'b1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr     = '0;
    wdata    = '0;
    b_rd_req = 1'b0;
    b_wr_req = 1'b0;
    b_addr   = '0;
    b_wdata  = '0;
    last_line = '0;

    $display("[TB] reset");
    repeat (3) waitCycle();
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_we_n", sram_we_n, 1);
    checkOutput("rst_sram_addr", sram_addr, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    waitCycle();
    checkOutput("post_rst_ready", ready, 1);

    $display("[TB] directed read 0x10");
    runRead(32'h0000_0010);
    checkOutput("dir_rd_line", rdata, 64'h4444_3333_2222_1111);

    $display("[TB] directed write 0x24");
    runWrite(32'h0000_0024, 32'hDEAD_BEEF, 1'b0);

    $display("[TB] simultaneous read and write");
    a = $urandom;
    runWrite(a, $urandom, 1'b1);
    runRead(a);

    $display("[TB] reset during read beat 2");
    a = $urandom;
    base = {a[18:3], 2'b00};
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    checkOutput("abort_accept_ready", ready, 0);
    for (int c = 1; c <= 2 * BEAT_LEN + 1; c++) begin
      waitCycle();
      checkOutput("abort_sram_addr", sram_addr, base + 18'((c - 1) / BEAT_LEN));
    end
    rst    = 1'b1;
    rd_req = 1'b0;
    waitCycle();
    checkOutput("abort_ready", ready, 1);
    checkOutput("abort_we_n", sram_we_n, 1);
    checkOutput("abort_sram_addr_zero", sram_addr, 0);
    checkOutput("abort_rvalid", rvalid, 0);
    checkOutput("abort_rdata", rdata, 0);
    rst = 1'b0;
    last_line = '0;
    for (int c = 0; c < 8; c++) begin
      waitCycle();
      checkOutput("abort_no_rvalid", rvalid, 0);
      checkOutput("abort_idle_ready", ready, 1);
    end
    runRead(a);

    $display("[TB] zero wait-state write");
    d = $urandom;
    a = $urandom;
    base = {a[18:2], 1'b0};
    b_wr_req = 1'b1;
    b_addr   = a;
    b_wdata  = d;
    #1;
    checkOutput("w0_accept_ready", b_ready, 0);
    for (int c = 1; c <= 2; c++) begin
      waitCycle();
      b_wdata = $urandom;
      checkOutput("w0_busy_ready", b_ready, 0);
      checkOutput("w0_we_n", b_sram_we_n, 0);
      checkOutput("w0_sram_addr", b_sram_addr, base + 18'(c - 1));
      checkOutput("w0_dq", b_sram_dq, (c == 1) ? d[15:0] : d[31:16]);
    end
    waitCycle();
    checkOutput("w0_done_ready", b_ready, 1);
    checkOutput("w0_done_we_n", b_sram_we_n, 1);
    checkOutput("w0_done_rvalid", b_rvalid, 0);
    checkOutput("w0_rdata", b_rdata, 0);
    b_wr_req = 1'b0;
    waitCycle();
    checkOutput("w0_idle_ready", b_ready, 1);

    $display("[TB] random accesses");
    for (int n = 0; n < 12; n++) begin
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      if (op == 0) begin
        runRead(a);
      end else if (op == 1) begin
        runWrite(a, $urandom, 1'b0);
      end else begin
        runWrite(a, $urandom, 1'b1);
        runRead($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
